// File: rtl/wb_master_bridge.sv
// Core single-request port to classic Wishbone master bridge with address rebasing and timeout.
// Optional WB_INPUT_REG_EN registers ack/err/dat and adds a DRAIN cycle before the response.
module wb_master_bridge #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_OFFSET    = '0,
  parameter int unsigned            ADDR_SHIFT     = 0,
  parameter int unsigned            TIMEOUT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0]  TIMEOUT_RDATA  = '0
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_sel_i,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
  output logic                    cpu_ready_o,
  output logic                    cpu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
  output logic                    cpu_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int unsigned SelWidth = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [SelWidth-1:0]     sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rsp_q, rsp_d;
  logic                    err_q, err_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   rebased;
  logic                    timeout_hit;

  // Subtraction wraps on underflow by design; shift result is truncated to ADDR_WIDTH.
  assign rebased     = cpu_addr_i - ADDR_OFFSET;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

`ifdef WB_INPUT_REG_EN
  logic                  ack_r, err_r;
  logic [DATA_WIDTH-1:0] dat_r;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      dat_r <= '0;
    end else begin
      ack_r <= wb_ack_i;
      err_r <= wb_err_i;
      dat_r <= wb_dat_i;
    end
  end
`endif

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req_i) begin
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          adr_d   = rebased << ADDR_SHIFT;
          wdat_d  = cpu_wdata_i;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 32'd1;
`ifdef WB_INPUT_REG_EN
        if (wb_err_i || wb_ack_i) begin
          state_d = StDrain;
        end else if (timeout_hit) begin
`else
        if (wb_err_i) begin
          rsp_d   = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (wb_ack_i) begin
          rsp_d   = 1'b1;
          if (!we_q) rdata_d = wb_dat_i;
          state_d = StIdle;
        end else if (timeout_hit) begin
`endif
          rsp_d   = 1'b1;
          err_d   = 1'b1;
          if (!we_q) rdata_d = TIMEOUT_RDATA;
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Only reachable with the input register stage; the registered ack/err is visible here.
`ifdef WB_INPUT_REG_EN
        rsp_d = 1'b1;
        err_d = err_r;
        if (!err_r && ack_r && !we_q) rdata_d = dat_r;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_ready_o     = (state_q == StIdle);
  assign cpu_rsp_valid_o = rsp_q;
  assign cpu_err_o       = err_q;
  assign cpu_rdata_o     = rdata_q;
  assign wb_cyc_o        = (state_q != StIdle);
  assign wb_stb_o        = (state_q != StIdle);
  assign wb_we_o         = we_q;
  assign wb_sel_o        = sel_q;
  assign wb_adr_o        = adr_q;
  assign wb_dat_o        = wdat_q;

endmodule
